// File: rtl/mmu_arbiter.sv
// mmu_arbiter: muxes instruction-fetch and load/store requests onto the single mmu port.
// Build option ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests (default: dm always wins).
module mmu_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_address,
  output logic [DATA_WIDTH-1:0] if_data,
  output logic                  if_ready,
  input  logic                  dm_req,
  input  logic                  dm_write,
  input  logic                  dm_signed,
  input  logic [1:0]            dm_width,
  input  logic [ADDR_WIDTH-1:0] dm_address,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ready,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic                  mem_signed_read,
  output logic [1:0]            mem_data_width,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  mem_ready
);

  // Same encoding as MMU_WIDTH_WORD in the core's define.v.
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RELEASE} state_t;

  state_t state;
  logic   grant_if;
  logic   grant_dm;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when dm holds priority for the next simultaneous request.
  logic   prio_dm;
`endif

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state == IDLE) begin
      if (if_req && dm_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_dm = prio_dm;
        grant_if = !prio_dm;
`else
        grant_dm = 1'b1;
`endif
      end else begin
        grant_dm = dm_req;
        grant_if = if_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      if_data         <= '0;
      if_ready        <= 1'b0;
      dm_rdata        <= '0;
      dm_ready        <= 1'b0;
      write_enable    <= 1'b0;
      read_enable     <= 1'b0;
      mem_signed_read <= 1'b0;
      mem_data_width  <= '0;
      address         <= '0;
      data_in         <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_dm         <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_dm) begin
            address         <= dm_address;
            data_in         <= dm_wdata;
            mem_data_width  <= dm_width;
            mem_signed_read <= dm_signed;
            write_enable    <= dm_write;
            read_enable     <= !dm_write;
            state           <= DM_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            prio_dm         <= 1'b0;
`endif
          end else if (grant_if) begin
            address         <= if_address;
            mem_data_width  <= WIDTH_WORD;
            mem_signed_read <= 1'b0;
            write_enable    <= 1'b0;
            read_enable     <= 1'b1;
            state           <= IF_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            prio_dm         <= 1'b1;
`endif
          end
        end
        IF_BUSY: begin
          if (mem_ready) begin
            if_data      <= data_out;
            if_ready     <= 1'b1;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            state        <= RELEASE;
          end
        end
        DM_BUSY: begin
          if (mem_ready) begin
            // read_enable still carries the latched direction: only loads update dm_rdata.
            if (read_enable) begin
              dm_rdata <= data_out;
            end
            dm_ready     <= 1'b1;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          if_ready <= 1'b0;
          dm_ready <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mmu_arbiter.md
# mmu_arbiter

Two-master arbiter in front of the `mmu` block. It multiplexes instruction-fetch requests and load/store data requests onto the single MMU request port and drives the MMU enable/ready handshake. It returns read data to the requester that owns the transaction. It sits between the core's fetch and memory stages and `mmu`.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request, held until if_ready
- if_address  input  ADDR_WIDTH  fetch address
- if_data  output  DATA_WIDTH  fetched word, registered
- if_ready  output  1  one-cycle completion pulse for fetch
- dm_req  input  1  data request, held until dm_ready
- dm_write  input  1  1 = store, 0 = load
- dm_signed  input  1  sign-extend load
- dm_width  input  2  access width code (`MMU_WIDTH_*` from define.v)
- dm_address  input  ADDR_WIDTH  data address
- dm_wdata  input  DATA_WIDTH  store data
- dm_rdata  output  DATA_WIDTH  load result, registered
- dm_ready  output  1  one-cycle completion pulse for data
- write_enable  output  1  to mmu
- read_enable  output  1  to mmu
- mem_signed_read  output  1  to mmu
- mem_data_width  output  2  to mmu
- address  output  ADDR_WIDTH  to mmu
- data_in  output  DATA_WIDTH  to mmu
- data_out  input  DATA_WIDTH  from mmu
- mem_ready  input  1  from mmu, completion of current access

## Operation
- States: IDLE, IF_BUSY, DM_BUSY, RELEASE.
- IDLE: all MMU controls low. On an edge with a pending request, the arbiter latches the winner's address, width, signed, wdata and direction into output registers and moves to IF_BUSY or DM_BUSY.
- Arbitration when both requests are high: dm wins by default. See Configuration.
- IF_BUSY: read_enable=1, write_enable=0, mem_data_width=`MMU_WIDTH_WORD, mem_signed_read=0.
- DM_BUSY: read_enable=!dm_write and write_enable=dm_write, taken from the latched values.
- BUSY → RELEASE on an edge where mem_ready=1. On the same edge:
  - read: data_out is captured into if_data or dm_rdata;
  - store: dm_rdata is unchanged.
- RELEASE lasts exactly one cycle:
  - both enables low, so the MMU sees a deassertion;
  - the owner's ready is high in this cycle only;
  - all requests are ignored;
  - next state is IDLE.
- MMU outputs stay constant for the whole BUSY state. Requester input changes after the grant are ignored.
- Requester drops req mid-transaction: the access still completes and ready still pulses.
- Requester keeps req high into IDLE: it is treated as a new request.
- if_data and dm_rdata hold their last captured value indefinitely.

## Timing
- Reset (async assert, sync release):
  - state=IDLE;
  - all outputs 0 (if_data, dm_rdata, address, data_in, mem_data_width, enables, readies);
  - round-robin pointer = dm.
- Reset asserted mid-transaction: enables drop immediately, no ready pulse is issued, and the transaction is lost.
- Latency: req sampled at edge 0 → MMU enable high from edge 0 → mem_ready sampled at edge k → owner ready high from edge k to edge k+1 → IDLE.
- Minimum cycle count per access is mem_ready latency + 2.
- Back-to-back: the earliest next grant is on the edge ending the first IDLE cycle after RELEASE.
- mem_ready seen in IDLE or RELEASE is ignored.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - when both requests are high in IDLE, the winner is the master not granted last;
  - the pointer updates on every grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, dm always wins a simultaneous request and no pointer is synthesized.

## Test plan
- Fetch only:
  - stimulus: if_req=1, if_address=0, MMU returns 32'h00200293 after 3 cycles;
  - response: read_enable high 3 cycles with mem_data_width=WORD, if_data=32'h00200293, if_ready one-cycle pulse, then IDLE.
- Store then load:
  - stimulus: dm store of 32'h69BABACA to 32'h01000000, then a load from the same address;
  - response: write_enable only on the first access, read_enable only on the second, dm_rdata=32'h69BABACA, two dm_ready pulses, a RELEASE gap with both enables low between them.
- Simultaneous requests, macro undefined:
  - stimulus: if_req and dm_req high together 3 times;
  - response: dm granted all 3 times and if starves while dm_req stays asserted.
- Simultaneous requests, ARB_ROUND_ROBIN_EN defined:
  - stimulus: if_req and dm_req continuously high;
  - response: grants alternate dm, if, dm, if.
- Input change mid-access:
  - stimulus: dm_address changes and dm_req drops during DM_BUSY;
  - response: address stays at the latched value, dm_ready still pulses once, arbiter returns to IDLE.
- Reset mid-access:
  - stimulus: reset_n low during IF_BUSY;
  - response: all outputs 0 asynchronously, no if_ready pulse, after release state is IDLE and a new fetch completes normally.
